// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: instruction flag bit positions and the
// packed entry layout used when dumping entries for pipeline traces.
package rob_pkg;

  localparam int FLAGS_W    = 3;
  localparam int FLAG_LOAD  = 0;
  localparam int FLAG_STORE = 1;
  localparam int FLAG_JUMP  = 2;

  // Packed entry image {live, done, exc, w, flags, reg, pc, val} at default widths.
  localparam int ENT_VAL_LSB   = 0;
  localparam int ENT_PC_LSB    = 32;
  localparam int ENT_REG_LSB   = 64;
  localparam int ENT_FLAGS_LSB = 69;
  localparam int ENT_W_BIT     = 72;
  localparam int ENT_EXC_BIT   = 73;
  localparam int ENT_DONE_BIT  = 74;
  localparam int ENT_LIVE_BIT  = 75;
  localparam int ENT_BITS      = 76;

endpackage

// File: rtl/rob_lookup.sv
// Youngest-writer search: walks entries oldest-to-youngest starting at head so
// the last match seen is the youngest. Purely combinational.
module rob_lookup #(
  parameter int DEPTH = 8,
  parameter int REG_W = 5,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]       live,
  input  logic [DEPTH-1:0]       w,
  input  logic [DEPTH*REG_W-1:0] regs,
  input  logic [TAG_W-1:0]       head,
  input  logic [REG_W-1:0]       lk_reg,
  output logic                   hit,
  output logic [TAG_W-1:0]       tag
);

  logic [TAG_W-1:0] idx;

  // Live entries always form the window starting at head, so age order is head+k.
  always_comb begin
    hit = 1'b0;
    tag = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + TAG_W'(k);
      if (live[idx] && w[idx] && (lk_reg != '0) &&
          (regs[int'(idx)*REG_W +: REG_W] == lk_reg)) begin
        hit = 1'b1;
        tag = idx;
      end
    end
  end

endmodule

// File: rtl/rob_param.sv
// Reorder buffer: in-order alloc, out-of-order multi-channel completion, in-order commit.
// Completion is visible one cycle later; a full buffer stalls alloc even when committing.
module rob_param
  import rob_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_W  = 5,
  parameter int N_CPL  = 2,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  input  logic [PC_W-1:0]         alloc_pc,
  input  logic [REG_W-1:0]        alloc_reg,
  input  logic                    alloc_w,
  input  logic [FLAGS_W-1:0]      alloc_flags,
  output logic [TAG_W-1:0]        alloc_tag,
  input  logic [N_CPL-1:0]        cpl_valid,
  input  logic [N_CPL*TAG_W-1:0]  cpl_tag,
  input  logic [N_CPL*DATA_W-1:0] cpl_val,
  input  logic [N_CPL-1:0]        cpl_exc,
  input  logic [REG_W-1:0]        lk_reg,
  output logic                    lk_hit,
  output logic                    lk_done,
  output logic [TAG_W-1:0]        lk_tag,
  output logic [DATA_W-1:0]       lk_val,
  output logic                    cm_valid,
  input  logic                    cm_ready,
  output logic [PC_W-1:0]         cm_pc,
  output logic [REG_W-1:0]        cm_reg,
  output logic                    cm_w,
  output logic [FLAGS_W-1:0]      cm_flags,
  output logic [DATA_W-1:0]       cm_val,
  output logic                    cm_exc,
  output logic [TAG_W:0]          count
);

  logic [DEPTH-1:0]   live_q, done_q, exc_q, w_q;
  logic [PC_W-1:0]    pc_q    [DEPTH];
  logic [REG_W-1:0]   reg_q   [DEPTH];
  logic [FLAGS_W-1:0] flags_q [DEPTH];
  logic [DATA_W-1:0]  val_q   [DEPTH];
  logic [TAG_W-1:0]   head_q, tail_q;
  logic [TAG_W:0]     count_q;

  logic                   alloc_fire, commit_fire;
  logic [DEPTH-1:0]       cpl_hit, cpl_e;
  logic [DATA_W-1:0]      cpl_v [DEPTH];
  logic [DEPTH*REG_W-1:0] regs_flat;

  // Gated by reset so every output reads 0 while reset is held.
  assign alloc_ready = reset && (count_q < (TAG_W+1)'(DEPTH));
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign alloc_tag   = tail_q;
  assign count       = count_q;

  assign cm_valid    = live_q[head_q] && done_q[head_q];
  assign commit_fire = cm_valid && cm_ready && !flush;
  assign cm_pc       = pc_q[head_q];
  assign cm_reg      = reg_q[head_q];
  assign cm_w        = w_q[head_q];
  assign cm_flags    = flags_q[head_q];
  assign cm_val      = val_q[head_q];
  assign cm_exc      = exc_q[head_q];

  // Walk channels high to low so the lowest index wins a tag collision.
  always_comb begin
    cpl_hit = '0;
    cpl_e   = '0;
    for (int e = 0; e < DEPTH; e++) cpl_v[e] = '0;
    for (int i = N_CPL-1; i >= 0; i--) begin
      if (cpl_valid[i] && live_q[cpl_tag[i*TAG_W +: TAG_W]]) begin
        cpl_hit[cpl_tag[i*TAG_W +: TAG_W]] = 1'b1;
        cpl_v[cpl_tag[i*TAG_W +: TAG_W]]   = cpl_val[i*DATA_W +: DATA_W];
        cpl_e[cpl_tag[i*TAG_W +: TAG_W]]   = cpl_exc[i];
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int e = 0; e < DEPTH; e++) regs_flat[e*REG_W +: REG_W] = reg_q[e];
  end

  rob_lookup #(.DEPTH(DEPTH), .REG_W(REG_W)) u_lookup (
    .live   (live_q),
    .w      (w_q),
    .regs   (regs_flat),
    .head   (head_q),
    .lk_reg (lk_reg),
    .hit    (lk_hit),
    .tag    (lk_tag)
  );

  assign lk_done = lk_hit && done_q[lk_tag];
  assign lk_val  = lk_done ? val_q[lk_tag] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q  <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      w_q     <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        pc_q[e]    <= '0;
        reg_q[e]   <= '0;
        flags_q[e] <= '0;
        val_q[e]   <= '0;
      end
    end else if (flush) begin
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (cpl_hit[e]) begin
          done_q[e] <= 1'b1;
          val_q[e]  <= cpl_v[e];
          exc_q[e]  <= cpl_e[e];
        end
      end
      if (alloc_fire) begin
        live_q[tail_q]  <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        exc_q[tail_q]   <= 1'b0;
        w_q[tail_q]     <= alloc_w;
        pc_q[tail_q]    <= alloc_pc;
        reg_q[tail_q]   <= alloc_reg;
        flags_q[tail_q] <= alloc_flags;
        val_q[tail_q]   <= '0;
        tail_q          <= tail_q + 1'b1;
      end
      if (commit_fire) begin
        live_q[head_q] <= 1'b0;
        head_q         <= head_q + 1'b1;
      end
      unique case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
